// File: rtl/lsu_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_host_pkg
// Description : Shared types and constants for the LSU host arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_host_pkg;

    localparam int HOST_ID_W  = 1;
    localparam int LSU_ADDR_W = 32;
    localparam int LSU_DATA_W = 32;
    localparam int LSU_BE_W   = 4;

    typedef struct packed {
        logic [LSU_ADDR_W-1:0] addr;
        logic                  we;
        logic [LSU_BE_W-1:0]   be;
        logic [LSU_DATA_W-1:0] wdata;
    } lsu_req_t;

    typedef struct packed {
        logic                  rvalid;
        logic                  err;
        logic [LSU_DATA_W-1:0] rdata;
    } lsu_rsp_t;

endpackage
`default_nettype wire

// File: rtl/lsu_rsp_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lsu_rsp_id_fifo
// Description : Small synchronous FIFO of host IDs with same-cycle push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_rsp_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == C_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == C_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & ~o_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= f_next(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lsu_host_arbiter
// Description : Round-robin 2:1 arbiter for req/gnt/rvalid LSU host ports.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_host_arbiter
    import lsu_host_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  h0_req_i,
    input  logic [ADDR_WIDTH-1:0] h0_addr_i,
    input  logic                  h0_we_i,
    input  logic [3:0]            h0_be_i,
    input  logic [DATA_WIDTH-1:0] h0_wdata_i,
    output logic                  h0_gnt_o,
    output logic                  h0_rvalid_o,
    output logic                  h0_err_o,
    output logic [DATA_WIDTH-1:0] h0_rdata_o,
    input  logic                  h1_req_i,
    input  logic [ADDR_WIDTH-1:0] h1_addr_i,
    input  logic                  h1_we_i,
    input  logic [3:0]            h1_be_i,
    input  logic [DATA_WIDTH-1:0] h1_wdata_i,
    output logic                  h1_gnt_o,
    output logic                  h1_rvalid_o,
    output logic                  h1_err_o,
    output logic [DATA_WIDTH-1:0] h1_rdata_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic                  mem_err_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  protocol_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    if (DATA_WIDTH != LSU_DATA_W) begin : g_bad_data_width
        $error("lsu_host_arbiter: DATA_WIDTH must be 32");
    end
    if (ADDR_WIDTH > LSU_ADDR_W || ADDR_WIDTH < 1) begin : g_bad_addr_width
        $error("lsu_host_arbiter: ADDR_WIDTH must be 1..32");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8) begin : g_bad_outstanding
        $error("lsu_host_arbiter: MAX_OUTSTANDING must be 1..8");
    end

    logic                 r_lock;
    logic                 r_lock_sel;
    logic                 r_last_grant;
    logic                 r_protocol_err;
    logic                 w_sel;
    logic                 w_req;
    logic                 w_grant;
    logic                 w_full;
    logic                 w_empty;
    logic [CNT_W-1:0]     w_count;
    logic [HOST_ID_W-1:0] w_head;
    lsu_req_t             w_req0;
    lsu_req_t             w_req1;
    lsu_req_t             w_req_sel;
    lsu_rsp_t             w_rsp0;
    lsu_rsp_t             w_rsp1;

    always_comb begin
        w_req0       = '0;
        w_req0.addr  = LSU_ADDR_W'(h0_addr_i);
        w_req0.we    = h0_we_i;
        w_req0.be    = h0_be_i;
        w_req0.wdata = h0_wdata_i;
        w_req1       = '0;
        w_req1.addr  = LSU_ADDR_W'(h1_addr_i);
        w_req1.we    = h1_we_i;
        w_req1.be    = h1_be_i;
        w_req1.wdata = h1_wdata_i;
    end

    // A stalled request keeps its port so the downstream fields stay stable until gnt.
    always_comb begin
        w_sel = 1'b0;
        if (r_lock) begin
            w_sel = r_lock_sel;
        end else if (h0_req_i && !h1_req_i) begin
            w_sel = 1'b0;
        end else if (h1_req_i && !h0_req_i) begin
            w_sel = 1'b1;
        end else if (h0_req_i && h1_req_i) begin
            w_sel = ~r_last_grant;
        end
    end

    assign w_req   = (h0_req_i | h1_req_i) & ~w_full;
    assign w_grant = w_req & mem_gnt_i;

    always_comb begin
        w_req_sel = '0;
        if (w_req) begin
            w_req_sel = w_sel ? w_req1 : w_req0;
        end
    end

    assign mem_req_o   = w_req;
    assign mem_addr_o  = w_req_sel.addr[ADDR_WIDTH-1:0];
    assign mem_we_o    = w_req_sel.we;
    assign mem_be_o    = w_req_sel.be;
    assign mem_wdata_o = w_req_sel.wdata;
    assign h0_gnt_o    = w_grant & ~w_sel;
    assign h1_gnt_o    = w_grant & w_sel;

    lsu_rsp_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (HOST_ID_W)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_grant),
        .i_data  (HOST_ID_W'(w_sel)),
        .i_pop   (mem_rvalid_i),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_rsp0        = '0;
        w_rsp1        = '0;
        w_rsp0.rvalid = mem_rvalid_i & ~w_empty & (w_head == HOST_ID_W'(0));
        w_rsp1.rvalid = mem_rvalid_i & ~w_empty & (w_head == HOST_ID_W'(1));
        w_rsp0.err    = mem_err_i & w_rsp0.rvalid;
        w_rsp1.err    = mem_err_i & w_rsp1.rvalid;
        w_rsp0.rdata  = mem_rdata_i;
        w_rsp1.rdata  = mem_rdata_i;
    end

    assign h0_rvalid_o    = w_rsp0.rvalid;
    assign h0_err_o       = w_rsp0.err;
    assign h0_rdata_o     = w_rsp0.rdata;
    assign h1_rvalid_o    = w_rsp1.rvalid;
    assign h1_err_o       = w_rsp1.err;
    assign h1_rdata_o     = w_rsp1.rdata;
    assign protocol_err_o = r_protocol_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock         <= 1'b0;
            r_lock_sel     <= 1'b0;
            r_last_grant   <= 1'b1;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_req && !mem_gnt_i) begin
                r_lock     <= 1'b1;
                r_lock_sel <= w_sel;
            end else if (w_grant) begin
                r_lock <= 1'b0;
            end
            if (w_grant) begin
                r_last_grant <= w_sel;
            end
            // A response with nothing outstanding (including one racing the first push).
            if (mem_rvalid_i && (w_count == '0)) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_host_arbiter
// Description : Directed plus randomized self-checking bench for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_host_arbiter;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        h0_req_i = 1'b0, h1_req_i = 1'b0;
    logic [31:0] h0_addr_i = '0, h1_addr_i = '0;
    logic        h0_we_i = 1'b0, h1_we_i = 1'b0;
    logic [3:0]  h0_be_i = '0, h1_be_i = '0;
    logic [31:0] h0_wdata_i = '0, h1_wdata_i = '0;
    logic        h0_gnt_o, h1_gnt_o, h0_rvalid_o, h1_rvalid_o, h0_err_o, h1_err_o;
    logic [31:0] h0_rdata_o, h1_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        protocol_err_o;

    always #5 clk = ~clk;

    lsu_host_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk (clk), .rst (rst),
        .h0_req_i (h0_req_i), .h0_addr_i (h0_addr_i), .h0_we_i (h0_we_i),
        .h0_be_i (h0_be_i), .h0_wdata_i (h0_wdata_i), .h0_gnt_o (h0_gnt_o),
        .h0_rvalid_o (h0_rvalid_o), .h0_err_o (h0_err_o), .h0_rdata_o (h0_rdata_o),
        .h1_req_i (h1_req_i), .h1_addr_i (h1_addr_i), .h1_we_i (h1_we_i),
        .h1_be_i (h1_be_i), .h1_wdata_i (h1_wdata_i), .h1_gnt_o (h1_gnt_o),
        .h1_rvalid_o (h1_rvalid_o), .h1_err_o (h1_err_o), .h1_rdata_o (h1_rdata_o),
        .mem_req_o (mem_req_o), .mem_addr_o (mem_addr_o), .mem_we_o (mem_we_o),
        .mem_be_o (mem_be_o), .mem_wdata_o (mem_wdata_o), .mem_gnt_i (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i), .mem_err_i (mem_err_i),
        .mem_rdata_i (mem_rdata_i), .protocol_err_o (protocol_err_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: outstanding host IDs in grant order plus arbitration memory.
    int q[$];
    bit m_last = 1'b1;
    bit m_lock = 1'b0;
    bit m_lock_sel = 1'b0;
    bit m_perr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit h1_busy();
        foreach (q[i]) if (q[i] == 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic new_req(input bit h, input logic [31:0] addr);
        if (!h) begin
            h0_req_i = 1'b1; h0_addr_i = addr; h0_we_i = 1'($urandom);
            h0_be_i = 4'($urandom); h0_wdata_i = $urandom;
        end else begin
            h1_req_i = 1'b1; h1_addr_i = addr; h1_we_i = 1'($urandom);
            h1_be_i = 4'($urandom); h1_wdata_i = $urandom;
        end
    endtask

    task automatic step(input bit r, input bit g, input bit rv, input bit er,
                        input logic [31:0] rd);
        bit full, ereq, sel, erv0, erv1;
        logic [31:0] ea, ewd;
        logic [3:0]  ebe;
        bit ewe;
        rst = r; mem_gnt_i = g; mem_rvalid_i = rv; mem_err_i = er; mem_rdata_i = rd;
        #1;
        full = (q.size() >= MAXO);
        ereq = (h0_req_i || h1_req_i) && !full;
        if (m_lock)                      sel = m_lock_sel;
        else if (h0_req_i && !h1_req_i)  sel = 1'b0;
        else if (h1_req_i && !h0_req_i)  sel = 1'b1;
        else                             sel = !m_last;
        ea  = !ereq ? 32'h0 : (sel ? h1_addr_i  : h0_addr_i);
        ewd = !ereq ? 32'h0 : (sel ? h1_wdata_i : h0_wdata_i);
        ebe = !ereq ? 4'h0  : (sel ? h1_be_i    : h0_be_i);
        ewe = !ereq ? 1'b0  : (sel ? h1_we_i    : h0_we_i);
        erv0 = rv && q.size() > 0 && q[0] == 0;
        erv1 = rv && q.size() > 0 && q[0] == 1;
        chk("mem_req",   32'(mem_req_o),   32'(ereq));
        chk("h0_gnt",    32'(h0_gnt_o),    32'(ereq && g && !sel));
        chk("h1_gnt",    32'(h1_gnt_o),    32'(ereq && g && sel));
        chk("mem_addr",  mem_addr_o,       ea);
        chk("mem_wdata", mem_wdata_o,      ewd);
        chk("mem_be",    32'(mem_be_o),    32'(ebe));
        chk("mem_we",    32'(mem_we_o),    32'(ewe));
        chk("h0_rvalid", 32'(h0_rvalid_o), 32'(erv0));
        chk("h1_rvalid", 32'(h1_rvalid_o), 32'(erv1));
        chk("h0_err",    32'(h0_err_o),    32'(erv0 && er));
        chk("h1_err",    32'(h1_err_o),    32'(erv1 && er));
        chk("h0_rdata",  h0_rdata_o,       rd);
        chk("h1_rdata",  h1_rdata_o,       rd);
        chk("perr",      32'(protocol_err_o), 32'(m_perr));
        @(posedge clk);
        #1;
        if (ereq && g) begin
            if (sel) h1_req_i = 1'b0; else h0_req_i = 1'b0;
        end
        if (r) begin
            q.delete(); m_last = 1'b1; m_lock = 1'b0; m_perr = 1'b0;
        end else begin
            if (rv) begin
                if (q.size() > 0) void'(q.pop_front());
                else              m_perr = 1'b1;
            end
            if (ereq && g) begin
                q.push_back(int'(sel)); m_last = sel; m_lock = 1'b0;
            end else if (ereq) begin
                m_lock = 1'b1; m_lock_sel = sel;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() > 0; i++) step(0, 0, 1, 0, $urandom);
    endtask

    initial begin
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);

        // Single h0 read answered one cycle after its grant.
        new_req(0, 32'h100); h0_we_i = 1'b0;
        step(0, 1, 0, 0, 32'h0);
        step(0, 0, 1, 0, 32'hDEADBEEF);

        // Both hosts requesting continuously: grants alternate.
        for (int i = 0; i < 8; i++) begin
            if (!h0_req_i) new_req(0, 32'h1000 + 32'(i * 4));
            if (!h1_req_i && !h1_busy()) new_req(1, 32'h2000 + 32'(i * 4));
            step(0, 1, q.size() > 0, 1'($urandom), $urandom);
        end
        drain();

        // Stalled h1 keeps its address while h0 joins.
        new_req(1, 32'h200);
        step(0, 0, 0, 0, 32'h0);
        new_req(0, 32'h300);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        drain();

        // Three back-to-back h0 requests against a full ID FIFO.
        for (int i = 0; i < 3; i++) begin
            new_req(0, 32'h400 + 32'(i * 4));
            for (int k = 0; k < 4 && h0_req_i; k++) step(0, 1, k == 2, 0, $urandom);
        end
        while (h0_req_i) step(0, 1, 0, 0, $urandom);

        // Randomized traffic.
        drain();
        for (int i = 0; i < 400; i++) begin
            if (!h0_req_i && ($urandom % 3) == 0) new_req(0, {$urandom, 2'b00});
            if (!h1_req_i && !h1_busy() && ($urandom % 4) == 0) new_req(1, {$urandom, 2'b00});
            step(0, ($urandom % 4) != 0, q.size() > 0 && ($urandom % 2) == 1,
                 1'($urandom), $urandom);
        end

        // Reset with two outstanding, then a both-request contest.
        h0_req_i = 1'b0; h1_req_i = 1'b0;
        while (q.size() < MAXO) begin
            new_req(0, 32'h500);
            step(0, 1, 0, 0, 32'h0);
        end
        h0_req_i = 1'b0;
        step(1, 0, 0, 0, 32'h0);
        new_req(0, 32'h600);
        new_req(1, 32'h700);
        step(0, 1, 0, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        drain();

        // Response with nothing outstanding is sticky.
        step(1, 0, 0, 0, 32'h0);
        step(0, 0, 1, 1, 32'h12345678);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_host_arbiter.md
Name: lsu_host_arbiter

Overview:
- 2:1 arbiter for Ibex-style LSU host ports (req/gnt/rvalid protocol).
- Port h0 is the Ibex core data port. Port h1 is the AXI-slave bridge host port, which issues one request at a time.
- Output is a single downstream memory/peripheral port using the same protocol.
- Round-robin arbitration. Selection is locked while a request is stalled. Responses are routed in order via an ID FIFO, supporting up to MAX_OUTSTANDING granted-but-unanswered transfers.

Parameters:
ADDR_WIDTH, 32, address width, byte address.
DATA_WIDTH, 32, data width; must be 32 (elaboration $error otherwise).
MAX_OUTSTANDING, 2, maximum granted transfers awaiting rvalid; 1..8.

Ports:
clk  in  1  clock; single clock domain.
rst  in  1  reset; synchronous, active-high.
h0_req_i / h1_req_i  in  1  host request.
h0_addr_i / h1_addr_i  in  ADDR_WIDTH  word-aligned byte address.
h0_we_i / h1_we_i  in  1  write enable.
h0_be_i / h1_be_i  in  4  byte enables.
h0_wdata_i / h1_wdata_i  in  DATA_WIDTH  write data.
h0_gnt_o / h1_gnt_o  out  1  grant.
h0_rvalid_o / h1_rvalid_o  out  1  response valid.
h0_err_o / h1_err_o  out  1  response error, qualified by rvalid.
h0_rdata_o / h1_rdata_o  out  DATA_WIDTH  read data.
mem_req_o  out  1  downstream request.
mem_addr_o  out  ADDR_WIDTH  downstream address.
mem_we_o  out  1  downstream write enable.
mem_be_o  out  4  downstream byte enables.
mem_wdata_o  out  DATA_WIDTH  downstream write data.
mem_gnt_i  in  1  downstream grant.
mem_rvalid_i  in  1  downstream response valid.
mem_err_i  in  1  downstream error.
mem_rdata_i  in  DATA_WIDTH  downstream read data.
protocol_err_o  out  1  sticky: rvalid received with no outstanding transfer.

Behaviour:
- Reset (rst=1 at clk edge, any time, including mid-transfer):
  - FIFO emptied; count=0.
  - lock=0.
  - last_grant=1, so h0 wins the first contest.
  - protocol_err_o=0.
  - Outstanding responses are forgotten. Any rvalid arriving after reset raises protocol_err_o.
- Derived signals:
  - full = (count==MAX_OUTSTANDING). Conservative: a same-cycle pop does NOT unblock the request.
- Selection, sel in {0,1}:
  - If lock=1: sel=lock_sel.
  - Else if exactly one of h0_req_i/h1_req_i is high: sel is that port.
  - Else if both are high: sel = ~last_grant.
- Downstream request:
  - mem_req_o = (h0_req_i|h1_req_i) & ~full.
  - mem_addr_o/we/be/wdata = fields of port sel. They are zero when mem_req_o=0.
- Grant:
  - hX_gnt_o = mem_gnt_i & mem_req_o & (sel==X). Combinational, zero added latency.
  - The non-selected port sees gnt=0.
- Lock:
  - Set when mem_req_o & ~mem_gnt_i: lock<=1, lock_sel<=sel.
  - Cleared on mem_req_o & mem_gnt_i.
  - Guarantees the downstream address is stable from req to gnt.
  - While full, mem_req_o=0 and lock holds its value.
- On a grant (mem_req_o & mem_gnt_i):
  - Push sel into the ID FIFO.
  - last_grant<=sel.
  - count++.
- On mem_rvalid_i with count>0:
  - Pop the FIFO; route to head ID.
  - hX_rvalid_o = mem_rvalid_i & (head==X); same cycle, combinational.
  - hX_err_o = mem_err_i & hX_rvalid_o.
  - count--.
- rdata: mem_rdata_i is fanned out to both ports unmasked. Hosts qualify it with rvalid.
- Simultaneous grant and rvalid: push and pop in the same cycle; count unchanged.
  - rvalid in the same cycle as a grant into an empty FIFO is a protocol error, because the head becomes visible only on the next cycle.
- mem_rvalid_i with count==0:
  - protocol_err_o<=1 (sticky until rst).
  - No hX_rvalid_o is asserted; count stays 0 (no underflow).
- Responses are strictly in order. The downstream port must return rvalid in grant order.
- Timing: combinational path mem_gnt_i -> hX_gnt_o. The downstream gnt must not depend on hX_gnt_o.

Decomposition:
- Package lsu_host_pkg:
  - typedef struct lsu_req_t {addr, we, be, wdata}.
  - typedef lsu_rsp_t {rvalid, err, rdata}.
  - HOST_ID_W=1.
- Sub-module lsu_rsp_id_fifo:
  - Synchronous FIFO; depth MAX_OUTSTANDING, width HOST_ID_W.
  - Supports simultaneous push/pop.
  - Outputs: count, full, empty, head.

Test Plan:
1. h0 read of 0x100 with mem_gnt_i=1 immediately; rvalid 1 cycle later, rdata=0xDEADBEEF -> h0_gnt_o=1 in cycle 0; h0_rvalid_o=1 and h0_rdata_o=0xDEADBEEF in cycle 1; h1_rvalid_o=0.
2. h0 and h1 request continuously, mem_gnt_i=1 -> grants alternate h0,h1,h0,h1; responses route in the same order; last_grant toggles.
3. h1 requests 0x200 with mem_gnt_i=0 for 3 cycles, and h0 raises req in cycle 1 -> mem_addr_o stays 0x200 for all stalled cycles; h1 is granted in cycle 3; h0 is granted next.
4. MAX_OUTSTANDING=2, h0 issues 3 back-to-back requests with rvalid withheld -> 2 grants, then mem_req_o=0; the third is granted the cycle after the first rvalid.
5. mem_rvalid_i=1 with count=0 -> protocol_err_o=1 and stays 1; neither hX_rvalid_o pulses; count remains 0.
6. Assert rst with 2 outstanding -> next cycle count=0, lock=0, mem_req_o follows fresh requests; h0 wins the first both-request contest.
